// File: rtl/eth_pkg.sv
// Shared Ethernet framing types and constants for the transmit/receive paths.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DST,
        SRC,
        TYPE,
        PAYLOAD,
        PAD,
        FCS,
        GAP
    } eth_state_t;

    localparam int ETH_HDR_BYTES = 14;
    localparam int ETH_FCS_BYTES = 4;

    localparam logic [31:0] ETH_CRC_POLY = 32'hEDB88320;
    localparam logic [31:0] ETH_CRC_INIT = 32'hFFFFFFFF;

    // Byte idx (0 = most significant) of a MAC address, wire order.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [47:0] sh;
        sh = mac << {idx, 3'b000};
        return sh[47:40];
    endfunction

endpackage

// File: rtl/eth_crc32_step.sv
// One-byte step of the reflected Ethernet CRC-32 (poly 0xEDB88320), LSB first.
// Latency: purely combinational.
// Backpressure: none; caller decides when to register the result.
module eth_crc32_step
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    // Fold the byte into the low bits, then shift out eight bits one at a time.
    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ ETH_CRC_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet II frame serialiser: DST, SRC, TYPE, payload, zero pad, optional FCS (ETH_FRAME_TX_FCS_EN).
// Latency: first beat one cycle after start is accepted; payload byte out one cycle after its handshake.
// Backpressure: output register holds while eth_valid && !eth_ready; pay_ready only when that register can load.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter logic [47:0] SRC_MAC     = 48'h123456789ABC,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          LEN_W       = 11,
    parameter int          IFG_CYCLES  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [47:0]      dst_mac,
    input  logic [15:0]      ethertype,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [7:0]       pay_data,
    input  logic             pay_valid,
    output logic             pay_ready,
    output logic [7:0]       eth_data,
    output logic             eth_valid,
    input  logic             eth_ready,
    output logic             eth_last,
    output logic             busy,
    output logic             done
);

    localparam int GAP_W = $clog2(IFG_CYCLES + 2);

    eth_state_t       state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [47:0]      dst_q, dst_d;
    logic [15:0]      type_q, type_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [LEN_W:0]   pad_q, pad_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       eth_data_q, eth_data_d;
    logic             eth_valid_q, eth_valid_d;
    logic             eth_last_q, eth_last_d;
    logic             busy_q, busy_d;
    // Blocks start on the first IDLE cycle after the gap.
    logic             hold_q, hold_d;

    logic             load_en;
    logic             pay_fire;
    logic             to_tail;
    logic [LEN_W-1:0] len_clamp;
    logic [LEN_W:0]   pad_calc;

`ifdef ETH_FRAME_TX_FCS_EN
    logic [31:0] crc_q, crc_d;
    logic [31:0] crc_seed, crc_nxt;
    logic        crc_upd;
    logic [7:0]  fcs_byte;

    assign crc_seed = (state_q == IDLE) ? ETH_CRC_INIT : crc_q;
    assign fcs_byte = 8'((~crc_q) >> {cnt_q, 3'b000});

    eth_crc32_step u_crc (
        .crc_in  (crc_seed),
        .data_in (eth_data_d),
        .crc_out (crc_nxt)
    );

    // Accumulate CRC over every header/payload/pad byte as it enters the output register.
    always_comb begin
        crc_d = crc_upd ? crc_nxt : crc_q;
    end
`endif

    assign load_en   = !eth_valid_q || eth_ready;
    assign pay_ready = (state_q == PAYLOAD) && load_en && (rem_q != '0);
    assign pay_fire  = pay_ready && pay_valid;
    assign len_clamp = (payload_len > LEN_W'(MAX_PAYLOAD)) ? LEN_W'(MAX_PAYLOAD) : payload_len;
    assign pad_calc  = ({1'b0, len_clamp} < (LEN_W+1)'(MIN_PAYLOAD)) ?
                       ((LEN_W+1)'(MIN_PAYLOAD) - {1'b0, len_clamp}) : '0;

    // Frame sequencer: picks the next byte for the output register and advances the state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dst_d       = dst_q;
        type_d      = type_q;
        rem_d       = rem_q;
        pad_d       = pad_q;
        gap_d       = gap_q;
        eth_data_d  = eth_data_q;
        eth_valid_d = eth_valid_q;
        eth_last_d  = eth_last_q;
        busy_d      = busy_q;
        hold_d      = 1'b0;
        to_tail     = 1'b0;
`ifdef ETH_FRAME_TX_FCS_EN
        crc_upd     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (start && !hold_q) begin
                    dst_d       = dst_mac;
                    type_d      = ethertype;
                    rem_d       = len_clamp;
                    pad_d       = pad_calc;
                    eth_data_d  = dst_mac[47:40];
                    eth_valid_d = 1'b1;
                    eth_last_d  = 1'b0;
                    cnt_d       = 3'd1;
                    busy_d      = 1'b1;
                    state_d     = DST;
`ifdef ETH_FRAME_TX_FCS_EN
                    crc_upd     = 1'b1;
`endif
                end
            end
            DST, SRC: begin
                if (load_en) begin
                    eth_data_d  = mac_byte((state_q == DST) ? dst_q : SRC_MAC, cnt_q);
                    eth_valid_d = 1'b1;
`ifdef ETH_FRAME_TX_FCS_EN
                    crc_upd     = 1'b1;
`endif
                    if (cnt_q == 3'd5) begin
                        cnt_d   = 3'd0;
                        state_d = (state_q == DST) ? SRC : TYPE;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
            TYPE: begin
                if (load_en) begin
                    eth_data_d  = (cnt_q == 3'd0) ? type_q[15:8] : type_q[7:0];
                    eth_valid_d = 1'b1;
`ifdef ETH_FRAME_TX_FCS_EN
                    crc_upd     = 1'b1;
`endif
                    if (cnt_q == 3'd0) begin
                        cnt_d = 3'd1;
                    end else begin
                        cnt_d = 3'd0;
                        if (rem_q != '0)      state_d = PAYLOAD;
                        else if (pad_q != '0) state_d = PAD;
                        else                  to_tail = 1'b1;
                    end
                end
            end
            PAYLOAD: begin
                if (pay_fire) begin
                    eth_data_d  = pay_data;
                    eth_valid_d = 1'b1;
                    rem_d       = rem_q - 1'b1;
`ifdef ETH_FRAME_TX_FCS_EN
                    crc_upd     = 1'b1;
`endif
                    if (rem_q == LEN_W'(1)) begin
                        if (pad_q != '0) state_d = PAD;
                        else             to_tail = 1'b1;
                    end
                end else if (load_en) begin
                    // No payload byte this cycle: let the register run dry.
                    eth_valid_d = 1'b0;
                end
            end
            PAD: begin
                if (load_en) begin
                    eth_data_d  = 8'h00;
                    eth_valid_d = 1'b1;
                    pad_d       = pad_q - 1'b1;
`ifdef ETH_FRAME_TX_FCS_EN
                    crc_upd     = 1'b1;
`endif
                    if (pad_q == (LEN_W+1)'(1)) to_tail = 1'b1;
                end
            end
`ifdef ETH_FRAME_TX_FCS_EN
            FCS: begin
                if (load_en) begin
                    eth_data_d  = fcs_byte;
                    eth_valid_d = 1'b1;
                    if (cnt_q == 3'd3) begin
                        eth_last_d = 1'b1;
                        cnt_d      = 3'd0;
                        state_d    = GAP;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end
            end
`endif
            GAP: begin
                if (eth_valid_q) begin
                    // Last beat still pending; the gap starts once it transfers.
                    if (eth_ready) begin
                        eth_valid_d = 1'b0;
                        eth_last_d  = 1'b0;
                        gap_d       = GAP_W'(IFG_CYCLES);
                    end
                end else if (gap_q <= GAP_W'(1)) begin
                    gap_d   = '0;
                    busy_d  = 1'b0;
                    hold_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (to_tail) begin
`ifdef ETH_FRAME_TX_FCS_EN
            cnt_d      = 3'd0;
            state_d    = FCS;
`else
            eth_last_d = 1'b1;
            state_d    = GAP;
`endif
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dst_q       <= '0;
            type_q      <= '0;
            rem_q       <= '0;
            pad_q       <= '0;
            gap_q       <= '0;
            eth_data_q  <= '0;
            eth_valid_q <= 1'b0;
            eth_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            hold_q      <= 1'b0;
`ifdef ETH_FRAME_TX_FCS_EN
            crc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dst_q       <= dst_d;
            type_q      <= type_d;
            rem_q       <= rem_d;
            pad_q       <= pad_d;
            gap_q       <= gap_d;
            eth_data_q  <= eth_data_d;
            eth_valid_q <= eth_valid_d;
            eth_last_q  <= eth_last_d;
            busy_q      <= busy_d;
            hold_q      <= hold_d;
`ifdef ETH_FRAME_TX_FCS_EN
            crc_q       <= crc_d;
`endif
        end
    end

    assign eth_data  = eth_data_q;
    assign eth_valid = eth_valid_q;
    assign eth_last  = eth_last_q;
    assign busy      = busy_q;
    assign done      = eth_valid_q && eth_ready && eth_last_q;

endmodule

// File: tb/tb_eth_frame_tx.sv
// Randomised bench for eth_frame_tx against a byte-list reference frame model.
// Latency: checks first-beat timing and the inter-frame gap.
// Backpressure: drives random/toggling eth_ready and pay_valid gaps, checks stall stability.
module tb_eth_frame_tx;
    import eth_pkg::*;

    localparam logic [47:0] SRC_MAC_TB = 48'h123456789ABC;
    localparam int MIN_P = 46;
    localparam int MAX_P = 1500;
    localparam int LW    = 11;
    localparam int IFG   = 12;
`ifdef ETH_FRAME_TX_FCS_EN
    localparam int FCS_N = 4;
`else
    localparam int FCS_N = 0;
`endif

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [47:0]   dst_mac;
    logic [15:0]   ethertype;
    logic [LW-1:0] payload_len;
    logic [7:0]    pay_data;
    logic          pay_valid;
    logic          pay_ready;
    logic [7:0]    eth_data;
    logic          eth_valid;
    logic          eth_ready;
    logic          eth_last;
    logic          busy;
    logic          done;

    eth_frame_tx #(
        .SRC_MAC     (SRC_MAC_TB),
        .MIN_PAYLOAD (MIN_P),
        .MAX_PAYLOAD (MAX_P),
        .LEN_W       (LW),
        .IFG_CYCLES  (IFG)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dst_mac     (dst_mac),
        .ethertype   (ethertype),
        .payload_len (payload_len),
        .pay_data    (pay_data),
        .pay_valid   (pay_valid),
        .pay_ready   (pay_ready),
        .eth_data    (eth_data),
        .eth_valid   (eth_valid),
        .eth_ready   (eth_ready),
        .eth_last    (eth_last),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference CRC-32 (reflected), one byte at a time.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] b);
        logic [31:0] c;
        c = c_in ^ {24'h0, b};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    logic [7:0] pay_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] ref_q[$];
    int  pay_idx, rdy_mode, vld_mode, cyc;
    bit  mid_start;
    int  last_cnt, last_idx, done_cnt, done_err, stall_viol, pay_rdy_cyc, pay_hs;
    bit  prev_stall;
    logic [7:0] prev_data;
    logic prev_last;

    // Build the expected wire bytes for one frame from the framing rules.
    task automatic build(input logic [47:0] dst, input logic [15:0] typ, input int len, input int pat);
        int n;
        logic [47:0] s;
        logic [31:0] c;
        n = (len > MAX_P) ? MAX_P : len;
        s = SRC_MAC_TB;
        pay_q.delete(); exp_q.delete(); got_q.delete();
        for (int i = 0; i < n; i++) pay_q.push_back((pat == 0) ? 8'(i) : 8'($urandom));
        for (int i = 0; i < 6; i++) exp_q.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) exp_q.push_back(s[47-8*i -: 8]);
        exp_q.push_back(typ[15:8]);
        exp_q.push_back(typ[7:0]);
        for (int i = 0; i < n; i++) exp_q.push_back(pay_q[i]);
        while (exp_q.size() < 14 + MIN_P) exp_q.push_back(8'h00);
        if (FCS_N != 0) begin
            c = 32'hFFFFFFFF;
            foreach (exp_q[i]) c = crc_byte(c, exp_q[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) exp_q.push_back(c[8*i +: 8]);
        end
        pay_idx = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; done_err = 0;
        stall_viol = 0; pay_rdy_cyc = 0; pay_hs = 0; prev_stall = 0;
    endtask

    // One clock: drive inputs, observe settled outputs, advance past the next edge.
    task automatic tick();
        case (rdy_mode)
            0:       eth_ready = 1'b1;
            1:       eth_ready = (cyc % 2 == 0);
            default: eth_ready = ($urandom % 3 != 0);
        endcase
        pay_valid = (vld_mode == 0) ? 1'b1 : ($urandom % 10 < 6);
        pay_data  = (pay_idx < pay_q.size()) ? pay_q[pay_idx] : 8'($urandom);
        if (mid_start) begin
            start       = ($urandom % 16 == 0);
            dst_mac     = 48'({$urandom, $urandom});
            payload_len = LW'($urandom);
        end
        #1;
        if (prev_stall && (!eth_valid || eth_data !== prev_data || eth_last !== prev_last)) stall_viol++;
        if (done !== (eth_valid && eth_ready && eth_last)) done_err++;
        if (done) done_cnt++;
        if (pay_ready) pay_rdy_cyc++;
        if (pay_ready && pay_valid) begin pay_hs++; pay_idx++; end
        if (eth_valid && eth_ready) begin
            got_q.push_back(eth_data);
            if (eth_last) begin last_cnt++; last_idx = got_q.size() - 1; end
        end
        prev_stall = eth_valid && !eth_ready;
        prev_data  = eth_data;
        prev_last  = eth_last;
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic collect();
        int n;
        n = 0;
        while (done_cnt == 0 && n < 20000) begin tick(); n++; end
        mid_start = 0;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        start = 1'b0;
        while (busy && n < 200) begin tick(); n++; end
        chk("idle_timeout", busy, 0);
        tick();
    endtask

    task automatic check_frame(input string tag, input int len);
        int n, eb, m, bad, idx;
        n  = (len > MAX_P) ? MAX_P : len;
        eb = ETH_HDR_BYTES + ((n > MIN_P) ? n : MIN_P) + FCS_N;
        chk({tag, "/beats"}, got_q.size(), eb);
        m = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        bad = -1;
        for (int i = 0; i < m; i++) if (bad < 0 && got_q[i] !== exp_q[i]) bad = i;
        if (m > 0) begin
            idx = (bad < 0) ? m - 1 : bad;
            chk($sformatf("%s/byte%0d", tag, idx), got_q[idx], exp_q[idx]);
        end
        chk({tag, "/last_cnt"}, last_cnt, 1);
        chk({tag, "/last_idx"}, last_idx, eb - 1);
        chk({tag, "/done_cnt"}, done_cnt, 1);
        chk({tag, "/done_err"}, done_err, 0);
        chk({tag, "/stall"}, stall_viol, 0);
        chk({tag, "/pay_hs"}, pay_hs, n);
    endtask

    task automatic launch(input logic [47:0] dst, input logic [15:0] typ, input int len);
        start = 1'b1; dst_mac = dst; ethertype = typ; payload_len = LW'(len);
        tick();
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [47:0] dst, input logic [15:0] typ, input int len,
                       input int pat, input int rm, input int vm, input bit mid);
        wait_idle();
        rdy_mode = rm; vld_mode = vm;
        build(dst, typ, len, pat);
        launch(dst, typ, len);
        mid_start = mid;
        collect();
        check_frame(tag, len);
    endtask

    initial begin : main
        int k, busy_hi, diff;
        logic [31:0] c;
        logic [7:0] kat[9];
        rst_n = 1'b0; start = 1'b0; dst_mac = '0; ethertype = '0; payload_len = '0;
        pay_data = '0; pay_valid = 1'b0; eth_ready = 1'b0;
        cyc = 0; mid_start = 0; rdy_mode = 0; vld_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/eth_valid", eth_valid, 0);
        chk("rst/eth_data", eth_data, 0);
        chk("rst/eth_last", eth_last, 0);
        chk("rst/pay_ready", pay_ready, 0);
        chk("rst/busy", busy, 0);
        chk("rst/done", done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        if (FCS_N != 0) begin
            for (int i = 0; i < 9; i++) kat[i] = 8'h31 + 8'(i);
            c = 32'hFFFFFFFF;
            for (int i = 0; i < 9; i++) c = crc_byte(c, kat[i]);
            chk("crc_model_kat", ~c, 32'hCBF43926);
        end

        // Empty payload: all pad, payload port never asked.
        run("len0", 48'hA1A2A3A4A5A6, 16'h0800, 0, 0, 0, 0, 0);
        chk("len0/pay_rdy_cyc", pay_rdy_cyc, 0);

        // Incrementing payload, no stalls.
        run("len100", 48'h0011223344FF, 16'h86DD, 100, 0, 0, 0, 0);

        // Oversized request is clamped.
        run("len1600", 48'hFFFFFFFFFFFF, 16'h0806, 1600, 1, 2, 1, 0);

        // Same frame with and without stalls must yield the same bytes.
        run("len60_ref", 48'h02AABBCCDDEE, 16'h1234, 60, 0, 0, 0, 0);
        ref_q = got_q;
        run("len60_stall", 48'h02AABBCCDDEE, 16'h1234, 60, 0, 1, 1, 0);
        diff = (ref_q.size() == got_q.size()) ? 0 : 1;
        for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) if (ref_q[i] !== got_q[i]) diff++;
        chk("len60/stall_vs_nostall", diff, 0);

        // Random frames with random backpressure.
        for (int f = 0; f < 6; f++)
            run($sformatf("rand%0d", f), 48'({$urandom, $urandom}), 16'($urandom),
                $urandom_range(0, 120), 1, $urandom_range(0, 2), 1, 0);

        // Stray starts mid-frame, then start held through the gap.
        run("midstart", 48'h0A0B0C0D0E0F, 16'h0800, 30, 1, 2, 1, 1);
        rdy_mode = 0; vld_mode = 0;
        build(48'h665544332211, 16'h88CC, 10, 1);
        start = 1'b1; dst_mac = 48'h665544332211; ethertype = 16'h88CC; payload_len = LW'(10);
        k = 0; busy_hi = 0;
        while (!eth_valid && k < 100) begin
            if (busy) busy_hi++;
            tick();
            k++;
        end
        start = 1'b0;
        chk("gap/busy_cycles", busy_hi, IFG);
        chk("gap/first_beat_not_early", (k + 1) >= (IFG + 1), 1);
        collect();
        check_frame("after_gap", 10);

        // Reset in the middle of the payload.
        wait_idle();
        rdy_mode = 0; vld_mode = 0;
        build(48'h111111111111, 16'h0800, 80, 1);
        launch(48'h111111111111, 16'h0800, 80);
        repeat (30) tick();
        chk("pre_rst/in_payload", pay_ready, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst/eth_valid", eth_valid, 0);
        chk("midrst/eth_data", eth_data, 0);
        chk("midrst/eth_last", eth_last, 0);
        chk("midrst/pay_ready", pay_ready, 0);
        chk("midrst/busy", busy, 0);
        chk("midrst/done", done, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete(); prev_stall = 0;
        repeat (5) tick();
        chk("postrst/no_beats", got_q.size(), 0);
        run("postrst", 48'hC0FFEE123456, 16'h0800, 50, 1, 2, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_tx.md
Name: eth_frame_tx

Overview:
Parametrised Ethernet II frame transmitter. Serialises destination MAC, source MAC, EtherType and a streamed payload into a byte stream, with valid/ready handshakes on both sides.
- Pads short payloads to the Ethernet minimum.
- Enforces an inter-frame gap between frames.
- Sits between packet builders (UDP/ARP) and the PHY/MAC byte interface.

Parameters:
SRC_MAC, 48'h123456789ABC, source MAC address sent in bytes 6-11, MSB byte first
MIN_PAYLOAD, 46, minimum payload bytes; shorter payloads are zero-padded up to this length
MAX_PAYLOAD, 1500, maximum payload bytes; longer requests are clamped to this length
LEN_W, 11, width of payload_len
IFG_CYCLES, 12, idle cycles forced after the last beat before the next start is accepted

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  frame request, sampled only in IDLE
dst_mac  in  48  destination MAC, latched on accepted start
ethertype  in  16  EtherType, latched on accepted start
payload_len  in  LEN_W  payload byte count, latched on accepted start
pay_data  in  8  payload byte
pay_valid  in  1  payload byte valid
pay_ready  out  1  payload byte accepted when pay_valid && pay_ready
eth_data  out  8  frame byte
eth_valid  out  1  frame byte valid
eth_ready  in  1  downstream accept; a beat transfers on eth_valid && eth_ready
eth_last  out  1  marks the final beat of the frame
busy  out  1  high from accepted start until the IFG expires
done  out  1  one-cycle pulse on the cycle the last beat transfers

Behaviour:
- Reset: eth_data=0, eth_valid=0, eth_last=0, pay_ready=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-frame aborts immediately; no partial beats are emitted after release.
- States and transitions:
  - IDLE: on start go to DST.
  - DST: 6 bytes, dst_mac[47:40] first; then SRC.
  - SRC: 6 bytes from SRC_MAC; then TYPE.
  - TYPE: 2 bytes, high byte first; then PAYLOAD, or PAD if the latched length is 0.
  - PAYLOAD: then PAD if the latched length < MIN_PAYLOAD, otherwise FCS (if enabled) or GAP.
  - PAD: zero bytes; then FCS (if enabled) or GAP.
  - GAP: then IDLE.
- Start acceptance: start accepted in IDLE only, which latches dst_mac, ethertype and min(payload_len, MAX_PAYLOAD). The first beat (eth_data=dst_mac[47:40], eth_valid=1) appears the next cycle. start is ignored while busy.
- Output register: loads a new byte when !eth_valid || eth_ready. eth_data and eth_last stay stable while eth_valid && !eth_ready.
- Payload handshake:
  - pay_ready = (state==PAYLOAD) && (!eth_valid || eth_ready) && (payload remaining > 0).
  - An accepted payload byte appears on eth_data the next cycle.
  - If pay_valid is low during PAYLOAD, eth_valid drops after the pending beat drains (bubble). The frame is not aborted.
- Pad count: MIN_PAYLOAD - len, computed at start in LEN_W+1 bits; 0 if len >= MIN_PAYLOAD.
- eth_last: set on the final FCS byte, or on the final payload/pad byte when FCS is compiled out. done pulses when that beat transfers.
- GAP: counts IFG_CYCLES cycles after done, then busy=0 and state returns to IDLE. start in the same cycle busy falls is ignored; it is accepted from the next cycle.
- Beat counts:
  - Without FCS: 14 + max(len, MIN_PAYLOAD).
  - With FCS: the above + 4.

Optional Feature:
- Macro ETH_FRAME_TX_FCS_EN.
- Defined:
  - CRC-32 runs over every byte from DST through PAD: reflected poly 32'hEDB88320, init 32'hFFFFFFFF, final XOR 32'hFFFFFFFF.
  - The CRC updates on each output-register load.
  - The FCS state appends 4 bytes, least significant byte first; eth_last is on the 4th.
- Undefined: no CRC logic, no FCS state; eth_last is on the final payload/pad byte.

Decomposition:
- Package eth_pkg:
  - State enum (IDLE, DST, SRC, TYPE, PAYLOAD, PAD, FCS, GAP).
  - ETH_HDR_BYTES=14, ETH_FCS_BYTES=4.
  - ETH_CRC_POLY=32'hEDB88320, ETH_CRC_INIT=32'hFFFFFFFF.
- Sub-module eth_crc32_step: combinational, next_crc = f(crc, byte). Instantiated only under ETH_FRAME_TX_FCS_EN; reusable by the receive side.

Test Plan:
- payload_len=0, eth_ready=1, FCS on -> 64 beats: 60 header+pad beats (pad all 0x00), eth_last and done on beat 64, pay_ready never high.
- payload_len=100, payload 0x00..0x63, FCS on -> 118 beats; bytes 14..113 equal the payload; FCS matches the software CRC-32 model.
- payload_len=1600 -> clamped: exactly 1500 pay_ready handshakes, 1518 beats with FCS (1514 without).
- eth_ready toggling 1,0,1,0 plus random pay_valid gaps, len=60 -> byte sequence identical to the no-stall run; eth_data stable during every stall cycle.
- start pulsed mid-frame and during GAP -> ignored; next frame's first beat is no earlier than IFG_CYCLES+1 cycles after done.
- rst_n low for 1 cycle during PAYLOAD -> all outputs 0 the same cycle; the next start yields a clean full frame starting with dst_mac[47:40].
